// File: rtl/shift_ctrl.sv
// Parallel-to-serial / serial-to-parallel shift controller with a clock prescaler,
// latched shift direction, abort and a one-cycle DONE handshake.
//
// state | meaning
// IDLE  | waiting for start_valid; start_ready high unless abort
// SHIFT | shifting one bit per prescaled tick, WIDTH ticks in total
// DONE  | one cycle, rx_valid high and rx_data holds the received word
module shift_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             dir,
  input  logic             abort,
  input  logic             sdi,
  output logic             sdo,
  output logic             shift_tick,
  output logic             busy,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int BW = $clog2(WIDTH + 1);
  localparam int PW = 8;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_shifted;
  logic             dir_q;
  logic [PW-1:0]    pre_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             accept, last_tick;

  // start_ready already folds in !abort, so abort blocks acceptance here too
  assign accept     = start_valid && start_ready;
  assign sr_shifted = dir_q ? {sdi, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], sdi};
  assign last_tick  = shift_tick && (bit_cnt == BW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT: begin
        if (abort)          state_nxt = IDLE;
        else if (last_tick) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state == IDLE) && !abort;
    busy        = (state != IDLE);
    rx_valid    = (state == DONE);
    shift_tick  = (state == SHIFT) && (pre_cnt == PW'(DIV - 1));
    sdo         = 1'b0;
    if (state == SHIFT) sdo = dir_q ? sr[0] : sr[WIDTH-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr      <= '0;
      dir_q   <= 1'b0;
      pre_cnt <= '0;
      bit_cnt <= '0;
      rx_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sr      <= tx_data;
            dir_q   <= dir;
            pre_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          // abort wins over a coinciding final tick: rx_data is left untouched
          if (abort) begin
            pre_cnt <= '0;
            bit_cnt <= '0;
          end else if (shift_tick) begin
            sr      <= sr_shifted;
            pre_cnt <= '0;
            bit_cnt <= bit_cnt + BW'(1);
            if (last_tick) rx_data <= sr_shifted;
          end else begin
            pre_cnt <= pre_cnt + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_ctrl.sv
// Self-checking bench for shift_ctrl: WIDTH=8 with DIV=1 and DIV=3 instances,
// compared against a bit-order model of the serial stream and received word.
module tb_shift_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       sv1, sv3, dir, abort, sdi_drv, sdi_drv3, loop1;
  logic [7:0] tx;
  logic       sdi1;

  logic       start_ready1, sdo1, shift_tick1, busy1, rx_valid1;
  logic [7:0] rx_data1;
  logic       start_ready3, sdo3, shift_tick3, busy3, rx_valid3;
  logic [7:0] rx_data3;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_rx = 8'h00;

  always #5 clk = ~clk;

  assign sdi1 = loop1 ? sdo1 : sdi_drv;

  shift_ctrl #(.WIDTH(8), .DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start_valid(sv1), .start_ready(start_ready1),
    .tx_data(tx), .dir(dir), .abort(abort), .sdi(sdi1), .sdo(sdo1),
    .shift_tick(shift_tick1), .busy(busy1), .rx_valid(rx_valid1), .rx_data(rx_data1)
  );

  shift_ctrl #(.WIDTH(8), .DIV(3)) dut3 (
    .clk(clk), .reset(reset), .start_valid(sv3), .start_ready(start_ready3),
    .tx_data(tx), .dir(dir), .abort(abort), .sdi(sdi_drv3), .sdo(sdo3),
    .shift_tick(shift_tick3), .busy(busy3), .rx_valid(rx_valid3), .rx_data(rx_data3)
  );

  task automatic wait_idle1();
    for (int i = 0; i < 100 && busy1; i++) @(negedge clk);
    checks++;
    if (busy1 !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy1=%b expected 0", busy1);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({start_ready1, busy1, rx_valid1, shift_tick1, sdo1} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags1: got %b expected 10000",
               {start_ready1, busy1, rx_valid1, shift_tick1, sdo1});
    end
    checks++;
    if (rx_data1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx1: got %h expected 00", rx_data1);
    end
    checks++;
    if ({start_ready3, busy3, rx_valid3, shift_tick3, sdo3, rx_data3} !== {5'b10000, 8'h00}) begin
      errors++;
      $display("FAIL reset_dut3: got %b expected 1000000000000",
               {start_ready3, busy3, rx_valid3, shift_tick3, sdo3, rx_data3});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One DIV=1 transfer; sdi either loops back sdo or follows a random bit list.
  task automatic test_transfer(input logic [7:0] txs, input logic d, input logic use_loop);
    logic       exp_sdo [8];
    logic       s [8];
    logic [7:0] exp_rx;
    wait_idle1();
    exp_rx = 8'h00;
    for (int k = 0; k < 8; k++) begin
      exp_sdo[k] = d ? txs[k] : txs[7-k];
      s[k]       = use_loop ? exp_sdo[k] : 1'($urandom_range(0, 1));
      exp_rx[d ? k : 7-k] = s[k];
    end
    loop1 = use_loop;
    tx    = txs;
    dir   = d;
    sv1   = 1'b1;
    checks++;
    if (start_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL xfer_ready: got %b expected 1", start_ready1);
    end
    @(negedge clk);
    sv1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({sdo1, shift_tick1, busy1, rx_valid1, start_ready1} !== {exp_sdo[k], 4'b1100}) begin
        errors++;
        $display("FAIL xfer_shift tx=%h dir=%b bit%0d: got sdo/tick/busy/rxv/rdy=%b expected %b",
                 txs, d, k, {sdo1, shift_tick1, busy1, rx_valid1, start_ready1},
                 {exp_sdo[k], 4'b1100});
      end
      sdi_drv = s[k];
      tx      = 8'($urandom);
      dir     = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    checks++;
    if (rx_valid1 !== 1'b1 || rx_data1 !== exp_rx) begin
      errors++;
      $display("FAIL xfer_done tx=%h dir=%b: got rxv=%b rx=%h expected rxv=1 rx=%h",
               txs, d, rx_valid1, rx_data1, exp_rx);
    end
    model_rx = exp_rx;
    @(negedge clk);
    checks++;
    if (rx_valid1 !== 1'b0 || busy1 !== 1'b0 || rx_data1 !== model_rx) begin
      errors++;
      $display("FAIL xfer_after: got rxv=%b busy=%b rx=%h expected 0 0 %h",
               rx_valid1, busy1, rx_data1, model_rx);
    end
  endtask

  task automatic test_div3();
    int ticks;
    for (int i = 0; i < 200 && busy3; i++) @(negedge clk);
    sdi_drv3 = 1'b1;
    tx       = 8'h00;
    sv3      = 1'b1;
    @(negedge clk);
    sv3   = 1'b0;
    ticks = 0;
    for (int c = 1; c <= 24; c++) begin
      checks++;
      if (shift_tick3 !== (c % 3 == 0) || rx_valid3 !== 1'b0 || busy3 !== 1'b1) begin
        errors++;
        $display("FAIL div3_cycle%0d: got tick/rxv/busy=%b%b%b expected %b01",
                 c, shift_tick3, rx_valid3, busy3, (c % 3 == 0));
      end
      if (shift_tick3 === 1'b1) ticks++;
      @(negedge clk);
    end
    checks++;
    if (rx_valid3 !== 1'b1 || rx_data3 !== 8'hFF || ticks != 8) begin
      errors++;
      $display("FAIL div3_done: got rxv=%b rx=%h ticks=%0d expected 1 ff 8",
               rx_valid3, rx_data3, ticks);
    end
  endtask

  // Abort raised in SHIFT cycle acyc with start_valid held; accept must wait for abort low.
  task automatic test_abort(input int acyc);
    logic [7:0] txs;
    wait_idle1();
    txs   = 8'($urandom);
    loop1 = 1'b1;
    tx    = txs;
    dir   = 1'($urandom_range(0, 1));
    sv1   = 1'b1;
    @(negedge clk);
    sv1 = 1'b0;
    for (int c = 1; c < acyc; c++) @(negedge clk);
    abort = 1'b1;
    sv1   = 1'b1;
    #1;
    checks++;
    if (start_ready1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL abort%0d_ready: got rdy=%b busy=%b expected 0 1", acyc, start_ready1, busy1);
    end
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || rx_valid1 !== 1'b0 || rx_data1 !== model_rx) begin
      errors++;
      $display("FAIL abort%0d_idle: got busy=%b rxv=%b rx=%h expected 0 0 %h",
               acyc, busy1, rx_valid1, rx_data1, model_rx);
    end
    abort = 1'b0;
    #1;
    checks++;
    if (start_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL abort%0d_release: got rdy=%b expected 1", acyc, start_ready1);
    end
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL abort%0d_reaccept: got busy=%b expected 1", acyc, busy1);
    end
    sv1 = 1'b0;
    for (int c = 1; c <= 8; c++) @(negedge clk);
    checks++;
    if (rx_valid1 !== 1'b1 || rx_data1 !== txs) begin
      errors++;
      $display("FAIL abort%0d_next: got rxv=%b rx=%h expected 1 %h", acyc, rx_valid1, rx_data1, txs);
    end
    model_rx = txs;
  endtask

  task automatic test_reset_mid();
    wait_idle1();
    loop1 = 1'b1;
    tx    = 8'hC3;
    dir   = 1'b0;
    sv1   = 1'b1;
    @(negedge clk);
    sv1 = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({start_ready1, busy1, rx_valid1, shift_tick1, sdo1, rx_data1} !== {5'b10000, 8'h00}) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b expected 1000000000000",
               {start_ready1, busy1, rx_valid1, shift_tick1, sdo1, rx_data1});
    end
    model_rx = 8'h00;
    @(negedge clk);
    checks++;
    if (rx_valid1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_hold: got rxv=%b busy=%b expected 0 0", rx_valid1, busy1);
    end
    reset = 1'b1;
    tx    = 8'h5A;
    sv1   = 1'b1;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_accept: got busy=%b expected 1", busy1);
    end
    sv1 = 1'b0;
    for (int c = 1; c <= 8; c++) @(negedge clk);
    checks++;
    if (rx_valid1 !== 1'b1 || rx_data1 !== 8'h5A) begin
      errors++;
      $display("FAIL rstmid_xfer: got rxv=%b rx=%h expected 1 5a", rx_valid1, rx_data1);
    end
    model_rx = 8'h5A;
  endtask

  task automatic test_back_to_back();
    int first, second;
    wait_idle1();
    first  = -1;
    second = -1;
    loop1  = 1'b1;
    dir    = 1'($urandom_range(0, 1));
    tx     = 8'h11;
    sv1    = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) tx = 8'h22;
      checks++;
      if (start_ready1 !== (c == 10 || c == 20) || rx_valid1 !== (c == 9 || c == 19)) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got rdy=%b rxv=%b expected %b %b",
                 c, start_ready1, rx_valid1, (c == 10 || c == 20), (c == 9 || c == 19));
      end
      if (rx_valid1 === 1'b1) begin
        if (first < 0) first = c;
        else           second = c;
      end
      if (c == 9 || c == 19) begin
        checks++;
        if (rx_data1 !== ((c == 9) ? 8'h11 : 8'h22)) begin
          errors++;
          $display("FAIL b2b_data%0d: got %h expected %h", c, rx_data1, (c == 9) ? 8'h11 : 8'h22);
        end
      end
    end
    sv1 = 1'b0;
    model_rx = 8'h22;
    checks++;
    if (first < 0 || second < 0 || second - first != 10) begin
      errors++;
      $display("FAIL b2b_spacing: got first=%0d second=%0d expected spacing 10", first, second);
    end
  endtask

  initial begin
    reset    = 1'b0;
    sv1      = 1'b0;
    sv3      = 1'b0;
    dir      = 1'b0;
    abort    = 1'b0;
    sdi_drv  = 1'b0;
    sdi_drv3 = 1'b0;
    loop1    = 1'b1;
    tx       = 8'h00;
    test_reset();
    test_transfer(8'h96, 1'b0, 1'b1);
    test_transfer(8'h96, 1'b1, 1'b1);
    test_div3();
    for (int i = 0; i < 8; i++)
      test_transfer(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    test_abort(4);
    test_abort(8);
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the shift word length in bits; legal values are 2 to 32.
REQ-002 The block SHALL have parameter DIV, default 1, meaning the clocks per shift tick; legal values are 1 to 255.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all flops update on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-005 Port start_valid SHALL be an input, 1 bit wide: requester offers a transfer.
REQ-006 Port start_ready SHALL be an output, 1 bit wide: the block can accept a transfer.
REQ-007 Port tx_data SHALL be an input, WIDTH bits wide: the parallel word to serialise.
REQ-008 Port dir SHALL be an input, 1 bit wide: 0 = MSB first (shift toward MSB, sdi enters bit 0); 1 = LSB first (shift toward LSB, sdi enters bit WIDTH-1).
REQ-009 Port abort SHALL be an input, 1 bit wide: synchronous cancel of the transfer in progress.
REQ-010 Port sdi SHALL be an input, 1 bit wide: serial data in.
REQ-011 Port sdo SHALL be an output, 1 bit wide: serial data out.
REQ-012 Port shift_tick SHALL be an output, 1 bit wide: high for one clock at each shift edge.
REQ-013 Port busy SHALL be an output, 1 bit wide: high whenever the state is not IDLE.
REQ-014 Port rx_valid SHALL be an output, 1 bit wide: one-cycle pulse that marks rx_data as new.
REQ-015 Port rx_data SHALL be an output, WIDTH bits wide: the received parallel word.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-017 start_ready SHALL equal 1 only in IDLE, and SHALL be 0 in any cycle where abort = 1.
REQ-018 A transfer SHALL be accepted on a rising edge where start_valid, start_ready and !abort all hold.
- On acceptance: the shift register loads tx_data, dir is latched, the tick and bit counters clear, and the next state is SHIFT.
REQ-019 While in SHIFT, tx_data and dir SHALL be ignored; only the latched dir takes effect.
REQ-020 The prescale counter SHALL run 0..DIV-1 in SHIFT, and shift_tick SHALL be 1 in each cycle where the count equals DIV-1.
- With DIV=1, shift_tick is 1 in every SHIFT cycle.
REQ-021 sdo SHALL be combinational from the register:
- register[WIDTH-1] when latched dir = 0;
- register[0] when latched dir = 1;
- 0 outside SHIFT.
REQ-022 On each tick edge, the register SHALL shift one position in the latched direction, sample sdi into the vacated bit, and increment the bit counter.
REQ-023 SHIFT SHALL last exactly WIDTH*DIV cycles; the edge of tick number WIDTH SHALL move the FSM to DONE.
REQ-024 DONE SHALL last exactly one cycle, with rx_valid = 1 and rx_data equal to the register; the next state is IDLE.
REQ-025 The latency from the acceptance edge to the rx_valid cycle SHALL be WIDTH*DIV+1 cycles; the next accept can occur on the edge that ends the IDLE cycle after DONE.
REQ-026 rx_data SHALL hold its value until the next DONE and SHALL NOT change on abort.
REQ-027 An abort seen at an edge in SHIFT SHALL move the FSM to IDLE with no rx_valid pulse and the counters cleared.
- Abort in IDLE or DONE has no effect, except that it blocks acceptance.
REQ-028 abort and the final tick on the same edge SHALL resolve as abort: go to IDLE, no rx_valid.
REQ-029 The bit counter SHALL be wide enough for WIDTH, and SHALL never wrap within a transfer.

Reset
REQ-030 While reset = 0, asynchronously:
- state = IDLE, and the shift register, rx_data, latched dir and counters are 0;
- start_ready = 1, and busy, rx_valid, shift_tick and sdo are 0.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer with no rx_valid pulse.
- The first accept after release is possible on the first rising edge with reset = 1.

Verification
REQ-032 WIDTH=8, DIV=1, sdi=sdo loopback, tx_data=0x96, dir=0:
- sdo over the 8 SHIFT cycles = 1,0,0,1,0,1,1,0;
- rx_valid 9 cycles after accept, rx_data=0x96.
REQ-033 Same setup with dir=1:
- sdo = 0,1,1,0,1,0,0,1;
- rx_data=0x96;
- changing dir or tx_data during SHIFT has no effect.
REQ-034 WIDTH=8, DIV=3, sdi held 1, tx_data=0x00:
- shift_tick every third cycle, 8 ticks in total;
- rx_valid 25 cycles after accept, rx_data=0xFF.
REQ-035 Abort during SHIFT (DIV=1, abort high in the 4th SHIFT cycle):
- IDLE next cycle, no rx_valid;
- rx_data keeps its previous value;
- start_valid held through that cycle is accepted only on the first edge with abort low.
REQ-036 reset pulled low in the 5th SHIFT cycle:
- all outputs go to reset values immediately, with no rx_valid;
- after release, a new 0x5A loopback transfer completes with rx_data=0x5A.
REQ-037 Back-to-back transfers (start_valid held high, 0x11 then 0x22):
- start_ready is high only in the IDLE cycle between transfers;
- two rx_valid pulses, 10 cycles apart (WIDTH*DIV+2).
